pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Configurable MIPS pipeline stage register: payload plus valid/PC/bd/exception/Tnew
// side-band, with hold-or-bubble stalls, flush, exception redirect and perf counters.
module pipe_stage_reg #(
    parameter int          DW         = 64,
    parameter int          PCW        = 32,
    parameter int          EXCW       = 5,
    parameter int          TW         = 2,
    parameter int          STALL_MODE = 0,
    parameter int          TNEW_DEC   = 0,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int          CNTW       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            req,
    input  logic            cnt_clr,
    input  logic            in_valid,
    input  logic [PCW-1:0]  in_pc,
    input  logic            in_bd,
    input  logic [EXCW-1:0] in_exc,
    input  logic [TW-1:0]   in_tnew,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    output logic [PCW-1:0]  out_pc,
    output logic            out_bd,
    output logic [EXCW-1:0] out_exc,
    output logic [TW-1:0]   out_tnew,
    output logic [DW-1:0]   out_data,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] bubble_cnt
);

    localparam logic [PCW-1:0] HPC = PCW'(HANDLER_PC);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + CNTW'(1);
    endfunction

    // Tnew counts down toward 0 and never wraps.
    function automatic logic [TW-1:0] tnew_next(input logic [TW-1:0] t);
        if (TNEW_DEC != 0 && t != '0)
            return t - TW'(1);
        return t;
    endfunction

    logic            vld_p0;
    logic [PCW-1:0]  pc_p0;
    logic            bd_p0;
    logic [EXCW-1:0] exc_p0;
    logic [TW-1:0]   tnew_p0;
    logic [DW-1:0]   data_p0;
    logic [CNTW-1:0] stall_cnt_p0;
    logic [CNTW-1:0] bubble_cnt_p0;

    logic            nxt_vld;
    logic [PCW-1:0]  nxt_pc;
    logic            nxt_bd;
    logic [EXCW-1:0] nxt_exc;
    logic [TW-1:0]   nxt_tnew;
    logic [DW-1:0]   nxt_data;
    logic            bubble;
    logic            stall_ev;

    always_comb begin
        nxt_vld  = vld_p0;
        nxt_pc   = pc_p0;
        nxt_bd   = bd_p0;
        nxt_exc  = exc_p0;
        nxt_tnew = tnew_p0;
        nxt_data = data_p0;
        bubble   = 1'b0;
        if (req) begin
            bubble = 1'b1;
            nxt_pc = HPC;
            nxt_bd = 1'b0;
        end else if (flush) begin
            // A stalled flush keeps PC/bd so EPC still points at the squashed slot.
            bubble = 1'b1;
            nxt_pc = stall ? in_pc : '0;
            nxt_bd = stall & in_bd;
        end else if (stall) begin
            if (STALL_MODE != 0) begin
                bubble = 1'b1;
                nxt_pc = in_pc;
                nxt_bd = in_bd;
            end
        end else if (!in_valid) begin
            bubble = 1'b1;
            nxt_pc = in_pc;
            nxt_bd = in_bd;
        end else begin
            nxt_vld  = 1'b1;
            nxt_pc   = in_pc;
            nxt_bd   = in_bd;
            nxt_exc  = in_exc;
            nxt_tnew = tnew_next(in_tnew);
            nxt_data = in_data;
        end
        if (bubble) begin
            nxt_vld  = 1'b0;
            nxt_exc  = '0;
            nxt_tnew = '0;
            nxt_data = '0;
        end
    end

    assign stall_ev = stall & ~req & ~flush;

    // Stage boundary: upstream slot -> registered stage outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            pc_p0   <= '0;
            bd_p0   <= 1'b0;
            exc_p0  <= '0;
            tnew_p0 <= '0;
            data_p0 <= '0;
        end else begin
            vld_p0  <= nxt_vld;
            pc_p0   <= nxt_pc;
            bd_p0   <= nxt_bd;
            exc_p0  <= nxt_exc;
            tnew_p0 <= nxt_tnew;
            data_p0 <= nxt_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_p0  <= '0;
            bubble_cnt_p0 <= '0;
        end else if (cnt_clr) begin
            stall_cnt_p0  <= '0;
            bubble_cnt_p0 <= '0;
        end else begin
            if (stall_ev)
                stall_cnt_p0 <= sat_inc(stall_cnt_p0);
            if (bubble)
                bubble_cnt_p0 <= sat_inc(bubble_cnt_p0);
        end
    end

    assign out_valid  = vld_p0;
    assign out_pc     = pc_p0;
    assign out_bd     = bd_p0;
    assign out_exc    = exc_p0;
    assign out_tnew   = tnew_p0;
    assign out_data   = data_p0;
    assign stall_cnt  = stall_cnt_p0;
    assign bubble_cnt = bubble_cnt_p0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a hold-mode/Tnew-decrement/4-bit-counter instance
// and a bubble-mode/16-bit-counter instance share one stimulus stream.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [1:0]  tnew;
        logic [63:0] data;
        logic [15:0] sc;
        logic [15:0] bc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, req, cnt_clr, in_valid, in_bd;
    logic [31:0] in_pc;
    logic [4:0]  in_exc;
    logic [1:0]  in_tnew;
    logic [63:0] in_data;

    logic        o0_valid, o0_bd, o1_valid, o1_bd;
    logic [31:0] o0_pc, o1_pc;
    logic [4:0]  o0_exc, o1_exc;
    logic [1:0]  o0_tnew, o1_tnew;
    logic [63:0] o0_data, o1_data;
    logic [3:0]  o0_sc, o0_bc;
    logic [15:0] o1_sc, o1_bc;

    exp_t  q0[$];
    exp_t  q1[$];
    string nq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.STALL_MODE(0), .TNEW_DEC(1), .CNTW(4)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
        .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(o0_valid), .out_pc(o0_pc), .out_bd(o0_bd), .out_exc(o0_exc),
        .out_tnew(o0_tnew), .out_data(o0_data), .stall_cnt(o0_sc), .bubble_cnt(o0_bc)
    );

    pipe_stage_reg #(.STALL_MODE(1), .TNEW_DEC(0), .CNTW(16)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
        .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(o1_valid), .out_pc(o1_pc), .out_bd(o1_bd), .out_exc(o1_exc),
        .out_tnew(o1_tnew), .out_data(o1_data), .stall_cnt(o1_sc), .bubble_cnt(o1_bc)
    );

    function automatic exp_t mk(input int v, input int pc, input int bd, input int exc,
                                input int tnew, input logic [63:0] data, input int sc,
                                input int bc);
        exp_t e;
        e.v    = v[0];
        e.pc   = 32'(pc);
        e.bd   = bd[0];
        e.exc  = 5'(exc);
        e.tnew = 2'(tnew);
        e.data = data;
        e.sc   = 16'(sc);
        e.bc   = 16'(bc);
        return e;
    endfunction

    function automatic int sat15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic compare(input string nm, input int which, input exp_t a, input exp_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s dut%0d: got v=%0d pc=%h bd=%0d exc=%h tnew=%0d data=%h sc=%0d bc=%0d ; want v=%0d pc=%h bd=%0d exc=%h tnew=%0d data=%h sc=%0d bc=%0d",
                     nm, which, a.v, a.pc, a.bd, a.exc, a.tnew, a.data, a.sc, a.bc,
                     e.v, e.pc, e.bd, e.exc, e.tnew, e.data, e.sc, e.bc);
        end
    endtask

    // Monitor: compares pending expectations at each negedge, or just after reset rises.
    initial begin
        forever begin
            @(negedge clk or posedge reset);
            #1;
            while (q0.size() > 0) begin
                exp_t  a0, a1, e0, e1;
                string nm;
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                nm = nq.pop_front();
                a0 = mk(int'(o0_valid), int'(o0_pc), int'(o0_bd), int'(o0_exc), int'(o0_tnew),
                        o0_data, int'(o0_sc), int'(o0_bc));
                a1 = mk(int'(o1_valid), int'(o1_pc), int'(o1_bd), int'(o1_exc), int'(o1_tnew),
                        o1_data, int'(o1_sc), int'(o1_bc));
                compare(nm, 0, a0, e0);
                compare(nm, 1, a1, e1);
            end
        end
    end

    task automatic push2(input string nm, input exp_t e0, input exp_t e1);
        q0.push_back(e0);
        q1.push_back(e1);
        nq.push_back(nm);
    endtask

    task automatic tick(input string nm, input exp_t e0, input exp_t e1);
        @(posedge clk);
        push2(nm, e0, e1);
        #1;
    endtask

    task automatic set_in(input int v, input int pc, input int bd, input int exc, input int tnew,
                          input logic [63:0] data, input int s, input int f, input int r,
                          input int c);
        in_valid = v[0];
        in_pc    = 32'(pc);
        in_bd    = bd[0];
        in_exc   = 5'(exc);
        in_tnew  = 2'(tnew);
        in_data  = data;
        stall    = s[0];
        flush    = f[0];
        req      = r[0];
        cnt_clr  = c[0];
    endtask

    task automatic areset(input string nm);
        @(negedge clk);
        #2;
        push2(nm, mk(0, 0, 0, 0, 0, 64'h0, 0, 0), mk(0, 0, 0, 0, 0, 64'h0, 0, 0));
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q0.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d_a, d_h, d_m;
        d_a = 64'hDEAD_BEEF_0000_0001;
        d_h = 64'hCAFE_F00D_1234_5678;
        d_m = 64'h0123_4567_89AB_CDEF;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        push2("reset_state", mk(0, 0, 0, 0, 0, 64'h0, 0, 0), mk(0, 0, 0, 0, 0, 64'h0, 0, 0));
        @(negedge clk);
        #2;
        reset = 1'b0;

        set_in(1, 32'h3000, 0, 0, 2, d_a, 0, 0, 0, 0);
        tick("load_tnew2", mk(1, 32'h3000, 0, 0, 1, d_a, 0, 0), mk(1, 32'h3000, 0, 0, 2, d_a, 0, 0));
        set_in(1, 32'h3004, 1, 5'h0A, 0, 64'h1234, 0, 0, 0, 0);
        tick("load_tnew0", mk(1, 32'h3004, 1, 5'h0A, 0, 64'h1234, 0, 0),
             mk(1, 32'h3004, 1, 5'h0A, 0, 64'h1234, 0, 0));

        set_in(1, 32'h3008, 0, 3, 1, 64'h5555, 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            tick("stall", mk(1, 32'h3004, 1, 5'h0A, 0, 64'h1234, i, 0),
                 mk(0, 32'h3008, 0, 0, 0, 64'h0, i, i));

        set_in(0, 32'h300C, 1, 2, 3, 64'h77, 0, 0, 0, 0);
        tick("invalid_bubble", mk(0, 32'h300C, 1, 0, 0, 64'h0, 3, 1),
             mk(0, 32'h300C, 1, 0, 0, 64'h0, 3, 4));

        set_in(1, 32'h3010, 1, 4, 2, 64'h99, 1, 1, 1, 0);
        tick("req_priority", mk(0, 32'h4180, 0, 0, 0, 64'h0, 3, 2),
             mk(0, 32'h4180, 0, 0, 0, 64'h0, 3, 5));
        set_in(1, 32'h3020, 1, 4, 2, 64'h99, 1, 1, 0, 0);
        tick("flush_stall", mk(0, 32'h3020, 1, 0, 0, 64'h0, 3, 3),
             mk(0, 32'h3020, 1, 0, 0, 64'h0, 3, 6));
        set_in(1, 32'h3020, 1, 4, 2, 64'h99, 0, 1, 0, 0);
        tick("flush_nostall", mk(0, 0, 0, 0, 0, 64'h0, 3, 4), mk(0, 0, 0, 0, 0, 64'h0, 3, 7));

        set_in(1, 32'h3030, 0, 1, 3, d_h, 0, 0, 0, 0);
        tick("load_exc", mk(1, 32'h3030, 0, 1, 2, d_h, 3, 4), mk(1, 32'h3030, 0, 1, 3, d_h, 3, 7));

        set_in(1, 32'h3040, 1, 0, 1, 64'hAA, 1, 0, 0, 0);
        for (int i = 1; i <= 20; i++)
            tick("stall_sat", mk(1, 32'h3030, 0, 1, 2, d_h, sat15(3 + i), 4),
                 mk(0, 32'h3040, 1, 0, 0, 64'h0, 3 + i, 7 + i));
        set_in(1, 32'h3040, 1, 0, 1, 64'hAA, 1, 0, 0, 1);
        tick("cnt_clr", mk(1, 32'h3030, 0, 1, 2, d_h, 0, 0), mk(0, 32'h3040, 1, 0, 0, 64'h0, 0, 0));
        set_in(1, 32'h3040, 1, 0, 1, 64'hAA, 1, 0, 0, 0);
        tick("after_clr", mk(1, 32'h3030, 0, 1, 2, d_h, 1, 0), mk(0, 32'h3040, 1, 0, 0, 64'h0, 1, 1));

        set_in(0, 32'h3050, 0, 0, 0, 64'h0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++)
            tick("bubble_sat", mk(0, 32'h3050, 0, 0, 0, 64'h0, 1, sat15(i)),
                 mk(0, 32'h3050, 0, 0, 0, 64'h0, 1, 1 + i));

        set_in(1, 32'h3060, 0, 0, 1, d_m, 0, 0, 0, 0);
        tick("load_pre_rst", mk(1, 32'h3060, 0, 0, 0, d_m, 1, 15), mk(1, 32'h3060, 0, 0, 1, d_m, 1, 17));
        areset("async_rst");
        set_in(1, 32'h3070, 1, 0, 2, 64'h42, 0, 0, 0, 0);
        tick("load_post_rst", mk(1, 32'h3070, 1, 0, 1, 64'h42, 0, 0),
             mk(1, 32'h3070, 1, 0, 2, 64'h42, 0, 0));

        for (int i = 0; i < 4 && q0.size() > 0; i++)
            @(negedge clk);
        #3;
        if (q0.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q0.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
